rom_fetch_arbiter: RTL and testbench

// - Shares one 16-bit ROM read port (SDRAM controller channel) between M68K program fetch and Z80 sound ROM fetch.
// - Driven by the prog_rom_cs / z80_rom_cs decodes; returns read data and the bus-hold signals: M68K DTACK gating and Z80 WAIT_n.
// - Holds a one-word hit register per requester, so repeated reads of the same word skip the memory port.

---
 rtl/rom_fetch_arbiter_pkg.sv | 19 +
 rtl/rom_fetch_arbiter_hit_reg.sv | 43 ++++
 rtl/rom_fetch_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types for the ROM fetch arbiter: FSM states, requester ids and the
// Z80 byte-lane helper.
package rom_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam logic REQ_M68K = 1'b0;
    localparam logic REQ_Z80  = 1'b1;

    // Even Z80 byte addresses live in the low half of the 16-bit word.
    function automatic logic [7:0] z80_lane(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_hit_reg.sv
// One-word hit register: remembers the last fetched word address and data for
// one requester and flags a hit when the current address matches.
module rom_hit_reg #(
    parameter int AW = 23
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inv_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [15:0]   load_data_i,
    input  logic [AW-1:0] cmp_addr_i,
    output logic          hit_o,
    output logic [15:0]   data_o
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;

    // Invalidate wins over a simultaneous load so a download never leaves stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (inv_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end
            if (load_i) begin
                addr_q <= load_addr_i;
                data_q <= load_data_i;
            end
        end
    end

    assign hit_o  = valid_q && (addr_q == cmp_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one 16-bit ROM read port between M68K program fetch and Z80 sound ROM
// fetch, with a one-word hit register per requester.
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int            AW            = 23,
    parameter logic [AW-1:0] Z80_WORD_BASE = 23'h010000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          rom_download,
    input  logic          m68k_rom_cs,
    input  logic [AW-1:0] m68k_a,
    output logic [15:0]   m68k_rom_data,
    output logic          m68k_rom_valid,
    input  logic          z80_rom_cs,
    input  logic          z80_rd_n,
    input  logic [15:0]   z80_addr,
    output logic [7:0]    z80_rom_data,
    output logic          z80_wait_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data
);

    // Memory handshake: mem_req rises with a stable mem_addr and is held until
    // the single-cycle mem_ack, which carries mem_data; acks outside REQ are ignored.

    arb_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          taint_q, taint_d;
    logic          m_valid_q, m_valid_d;
    logic [15:0]   m_data_q, m_data_d;
    logic          z_ready_q, z_ready_d;
    logic [7:0]    z_data_q, z_data_d;

    logic [AW-1:0] z80_word_addr;
    logic          m_hit, z_hit;
    logic [15:0]   m_hit_data, z_hit_data;
    logic          m_busy, z_busy;
    logic          m_pend, z_pend;
    logic          m_miss, z_miss;
    logic          ack_in_req;
    logic          cache_ok;
    logic          m_load, z_load;

    assign z80_word_addr = Z80_WORD_BASE + AW'(z80_addr[15:1]);

    assign m_busy = (state_q != ST_IDLE) && (grant_q == REQ_M68K);
    assign z_busy = (state_q != ST_IDLE) && (grant_q == REQ_Z80);
    assign m_pend = m68k_rom_cs && !m_valid_q && !m_busy;
    assign z_pend = z80_rom_cs && !z80_rd_n && !z_ready_q && !z_busy;
    assign m_miss = m_pend && !m_hit;
    assign z_miss = z_pend && !z_hit;

    // A download seen since the grant means the returning word may be stale.
    assign ack_in_req = (state_q == ST_REQ) && mem_ack;
    assign cache_ok   = ack_in_req && !rom_download && !taint_q;
    assign m_load     = cache_ok && (grant_q == REQ_M68K);
    assign z_load     = cache_ok && (grant_q == REQ_Z80);

    rom_hit_reg #(.AW(AW)) u_m68k_hit (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .inv_i       (rom_download),
        .load_i      (m_load),
        .load_addr_i (mem_addr_q),
        .load_data_i (mem_data),
        .cmp_addr_i  (m68k_a),
        .hit_o       (m_hit),
        .data_o      (m_hit_data)
    );

    rom_hit_reg #(.AW(AW)) u_z80_hit (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .inv_i       (rom_download),
        .load_i      (z_load),
        .load_addr_i (mem_addr_q),
        .load_data_i (mem_data),
        .cmp_addr_i  (z80_word_addr),
        .hit_o       (z_hit),
        .data_o      (z_hit_data)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        taint_d      = taint_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        z_ready_d    = z_ready_q;
        z_data_d     = z_data_q;

        if (!m68k_rom_cs) m_valid_d = 1'b0;
        if (!z80_rom_cs)  z_ready_d = 1'b0;

        if (m_pend && m_hit) begin
            m_valid_d = 1'b1;
            m_data_d  = m_hit_data;
        end
        if (z_pend && z_hit) begin
            z_ready_d = 1'b1;
            z_data_d  = z80_lane(z_hit_data, z80_addr[0]);
        end

        if (rom_download) taint_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (!rom_download && (m_miss || z_miss)) begin
                    if (m_miss && z_miss) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = z_miss ? REQ_Z80 : REQ_M68K;
                    end
                    mem_addr_d = (grant_d == REQ_M68K) ? m68k_a : z80_word_addr;
                    taint_d    = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // A requester that dropped its select still lets the fetch finish.
                if (mem_ack) begin
                    last_grant_d = grant_q;
                    state_d      = ST_DONE;
                    if (grant_q == REQ_M68K && m68k_rom_cs) begin
                        m_valid_d = 1'b1;
                        m_data_d  = mem_data;
                    end
                    if (grant_q == REQ_Z80 && z80_rom_cs) begin
                        z_ready_d = 1'b1;
                        z_data_d  = z80_lane(mem_data, z80_addr[0]);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_M68K;
            last_grant_q <= REQ_Z80;
            mem_addr_q   <= '0;
            taint_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            z_ready_q    <= 1'b0;
            z_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            taint_q      <= taint_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            z_ready_q    <= z_ready_d;
            z_data_q     <= z_data_d;
        end
    end

    assign mem_req        = (state_q == ST_REQ);
    assign mem_addr       = mem_addr_q;
    assign m68k_rom_valid = m_valid_q;
    assign m68k_rom_data  = m_data_q;
    assign z80_rom_data   = z_data_q;
    assign z80_wait_n     = ~(z80_rom_cs & ~z80_rd_n & ~z_ready_q);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: a latency-programmable memory
// responder plus a transaction-level model of hit registers and arbitration.
module tb_rom_fetch_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        rom_download;
    logic        m68k_rom_cs;
    logic [22:0] m68k_a;
    logic [15:0] m68k_rom_data;
    logic        m68k_rom_valid;
    logic        z80_rom_cs;
    logic        z80_rd_n;
    logic [15:0] z80_addr;
    logic [7:0]  z80_rom_data;
    logic        z80_wait_n;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    logic        resp_ack;
    logic        stray_ack;
    logic [15:0] resp_data;

    assign mem_ack  = resp_ack | stray_ack;
    assign mem_data = resp_data;

    always #5 clk_sys = ~clk_sys;

    rom_fetch_arbiter dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .rom_download   (rom_download),
        .m68k_rom_cs    (m68k_rom_cs),
        .m68k_a         (m68k_a),
        .m68k_rom_data  (m68k_rom_data),
        .m68k_rom_valid (m68k_rom_valid),
        .z80_rom_cs     (z80_rom_cs),
        .z80_rd_n       (z80_rd_n),
        .z80_addr       (z80_addr),
        .z80_rom_data   (z80_rom_data),
        .z80_wait_n     (z80_wait_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cnt = 0;
    int          mem_lat = 0;
    logic [22:0] exp_q[$];

    // Reference model state: what each hit register should hold, and who was served last.
    bit          m_cv, z_cv;
    logic [22:0] m_ca, z_ca;
    bit          last_g;   // 0 = M68K, 1 = Z80

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [22:0] a);
        logic [31:0] t;
        t = {9'd0, a} * 32'h0000_9E37 + 32'h0001_5A5A;
        return t[15:0] ^ t[31:16];
    endfunction

    function automatic logic [22:0] z_word(input logic [15:0] a);
        return 23'h010000 + {8'h00, a[15:1]};
    endfunction

    function automatic logic [7:0] z_byte(input logic [15:0] a);
        logic [15:0] w;
        w = mem_fn(z_word(a));
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Memory responder: acks mem_latency cycles after mem_req first appears.
    initial begin
        int          w;
        logic        prev;
        logic [22:0] held;
        w = 0; prev = 1'b0; held = '0;
        resp_ack = 1'b0; resp_data = '0;
        forever begin
            @(negedge clk_sys);
            resp_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (!prev) begin
                    req_cnt++;
                    held = mem_addr;
                    check("mem_req_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_q.size() > 0) check("mem_addr", mem_addr, exp_q.pop_front());
                end else begin
                    check("mem_addr_stable", mem_addr, held);
                end
                if (w >= mem_lat) begin
                    resp_ack  = 1'b1;
                    resp_data = mem_fn(mem_addr);
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
            prev = (mem_req === 1'b1);
        end
    end

    task automatic m68k_read(input logic [22:0] a, input int lat);
        bit hit;
        int n, r0;
        hit = m_cv && (m_ca == a);
        mem_lat = lat;
        r0 = req_cnt;
        if (!hit) exp_q.push_back(a);
        @(posedge clk_sys); #1;
        m68k_a = a; m68k_rom_cs = 1'b1;
        n = 0;
        @(negedge clk_sys);
        while (!m68k_rom_valid && n < 60) begin
            n++;
            @(negedge clk_sys);
        end
        check("m68k_latency", n, hit ? 1 : lat + 2);
        check("m68k_data", m68k_rom_data, mem_fn(a));
        check("m68k_mem_reqs", req_cnt - r0, hit ? 0 : 1);
        if (!hit) last_g = 1'b0;
        m_cv = 1'b1; m_ca = a;
        @(posedge clk_sys); #1;
        m68k_rom_cs = 1'b0;
        @(negedge clk_sys);
        check("m68k_valid_hold", m68k_rom_valid, 1);
        @(negedge clk_sys);
        check("m68k_valid_clear", m68k_rom_valid, 0);
    endtask

    task automatic z80_read(input logic [15:0] a, input int lat);
        bit          hit;
        int          n, r0;
        logic [22:0] zw;
        zw = z_word(a);
        hit = z_cv && (z_ca == zw);
        mem_lat = lat;
        r0 = req_cnt;
        if (!hit) exp_q.push_back(zw);
        @(posedge clk_sys); #1;
        z80_addr = a; z80_rom_cs = 1'b1; z80_rd_n = 1'b0;
        n = 0;
        @(negedge clk_sys);
        check("z80_wait_asserted", z80_wait_n, 0);
        while (!z80_wait_n && n < 60) begin
            n++;
            @(negedge clk_sys);
        end
        check("z80_latency", n, hit ? 1 : lat + 2);
        check("z80_data", z80_rom_data, z_byte(a));
        check("z80_mem_reqs", req_cnt - r0, hit ? 0 : 1);
        if (!hit) last_g = 1'b1;
        z_cv = 1'b1; z_ca = zw;
        @(posedge clk_sys); #1;
        z80_rom_cs = 1'b0; z80_rd_n = 1'b1;
        @(negedge clk_sys);
        check("z80_wait_idle", z80_wait_n, 1);
    endtask

    task automatic both_read(input logic [22:0] ma, input logic [15:0] za, input int lat);
        bit          mh, zh;
        int          em, ez, tm, tz;
        logic [22:0] zw;
        zw = z_word(za);
        mh = m_cv && (m_ca == ma);
        zh = z_cv && (z_ca == zw);
        mem_lat = lat;
        em = mh ? 1 : lat + 2;
        ez = zh ? 1 : lat + 2;
        if (!mh && !zh) begin
            if (last_g) begin
                ez = 2 * lat + 5;
                exp_q.push_back(ma); exp_q.push_back(zw);
                last_g = 1'b1;
            end else begin
                em = 2 * lat + 5;
                exp_q.push_back(zw); exp_q.push_back(ma);
                last_g = 1'b0;
            end
        end else if (!mh) begin
            exp_q.push_back(ma); last_g = 1'b0;
        end else if (!zh) begin
            exp_q.push_back(zw); last_g = 1'b1;
        end
        @(posedge clk_sys); #1;
        m68k_a = ma; m68k_rom_cs = 1'b1;
        z80_addr = za; z80_rom_cs = 1'b1; z80_rd_n = 1'b0;
        tm = -1; tz = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_sys);
            if (tm < 0 && m68k_rom_valid) tm = i;
            if (tz < 0 && z80_wait_n) tz = i;
            if (tm >= 0 && tz >= 0) break;
        end
        check("both_m68k_latency", tm, em);
        check("both_z80_latency", tz, ez);
        check("both_m68k_data", m68k_rom_data, mem_fn(ma));
        check("both_z80_data", z80_rom_data, z_byte(za));
        m_cv = 1'b1; m_ca = ma; z_cv = 1'b1; z_ca = zw;
        @(posedge clk_sys); #1;
        m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0; z80_rd_n = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Select dropped mid-fetch: the fetch runs to completion and is cached, but never signalled.
    task automatic abort_read(input logic [22:0] a, input int lat);
        int req_cycles;
        bit seen;
        exp_q.push_back(a);
        mem_lat = lat;
        req_cycles = 0; seen = 1'b0;
        @(posedge clk_sys); #1;
        m68k_a = a; m68k_rom_cs = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                @(posedge clk_sys); #1;
                m68k_rom_cs = 1'b0;
            end
            @(negedge clk_sys);
            if (mem_req) req_cycles++;
            if (m68k_rom_valid) seen = 1'b1;
        end
        check("abort_req_cycles", req_cycles, lat + 1);
        check("abort_valid_seen", seen, 0);
        m_cv = 1'b1; m_ca = a; last_g = 1'b0;
    endtask

    task automatic download_read(input logic [22:0] a, input int lat);
        int n, req_seen;
        m_cv = 1'b0; z_cv = 1'b0;
        mem_lat = lat;
        @(posedge clk_sys); #1;
        rom_download = 1'b1;
        @(posedge clk_sys); #1;
        m68k_a = a; m68k_rom_cs = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            if (mem_req || m68k_rom_valid) req_seen++;
        end
        check("dl_no_grant", req_seen, 0);
        exp_q.push_back(a);
        @(posedge clk_sys); #1;
        rom_download = 1'b0;
        n = 0;
        @(negedge clk_sys);
        while (!m68k_rom_valid && n < 60) begin
            n++;
            @(negedge clk_sys);
        end
        check("dl_latency", n, lat + 2);
        check("dl_data", m68k_rom_data, mem_fn(a));
        m_cv = 1'b1; m_ca = a; last_g = 1'b0;
        @(posedge clk_sys); #1;
        m68k_rom_cs = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Download pulse while the fetch is in flight: data is delivered but not cached.
    task automatic download_inflight(input logic [22:0] a, input int lat);
        int n;
        exp_q.push_back(a);
        mem_lat = lat;
        @(posedge clk_sys); #1;
        m68k_a = a; m68k_rom_cs = 1'b1;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                @(posedge clk_sys); #1; rom_download = 1'b1;
            end
            if (i == 3) begin
                @(posedge clk_sys); #1; rom_download = 1'b0;
            end
            @(negedge clk_sys);
            if (n < 0 && m68k_rom_valid) n = i;
        end
        check("dl_inflight_latency", n, lat + 2);
        check("dl_inflight_data", m68k_rom_data, mem_fn(a));
        m_cv = 1'b0; z_cv = 1'b0; last_g = 1'b0;
        @(posedge clk_sys); #1;
        m68k_rom_cs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_m68k_valid"}, m68k_rom_valid, 0);
        check({tag, "_m68k_data"}, m68k_rom_data, 0);
        check({tag, "_z80_data"}, z80_rom_data, 0);
        check({tag, "_z80_wait_n"}, z80_wait_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    logic [22:0] m_pool [4];
    logic [15:0] z_pool [6];

    initial begin
        m_pool = '{23'h000100, 23'h000101, 23'h7FFFFF, 23'h012345};
        z_pool = '{16'h0002, 16'h0003, 16'hFFFE, 16'hFFFF, 16'h1230, 16'h1231};
        reset = 1'b1; rom_download = 1'b0; stray_ack = 1'b0;
        m68k_rom_cs = 1'b0; m68k_a = '0;
        z80_rom_cs = 1'b0; z80_rd_n = 1'b1; z80_addr = '0;
        m_cv = 1'b0; z_cv = 1'b0; m_ca = '0; z_ca = '0; last_g = 1'b1;
        repeat (3) @(negedge clk_sys);
        check_reset_outputs("reset");
        #2 reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        m68k_read(23'h000100, 3);
        z80_read(16'h0003, 3);
        z80_read(16'h0002, 2);
        both_read(23'h000200, 16'h0100, 2);
        both_read(23'h000300, 16'h0200, 1);

        abort_read(23'h000400, 4);
        m68k_read(23'h000400, 2);

        // Stray ack while idle must not disturb anything.
        @(posedge clk_sys); #1; stray_ack = 1'b1;
        @(negedge clk_sys);
        check("stray_no_req", mem_req, 0);
        @(posedge clk_sys); #1; stray_ack = 1'b0;
        @(negedge clk_sys);
        check("stray_no_valid", m68k_rom_valid, 0);

        // Reset in the middle of a long fetch.
        exp_q.push_back(23'h000500);
        mem_lat = 10;
        @(posedge clk_sys); #1;
        m68k_a = 23'h000500; m68k_rom_cs = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("rst_pre_req", mem_req, 1);
        #2 reset = 1'b1;
        #1 check("rst_req_drop", mem_req, 0);
        m68k_rom_cs = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check_reset_outputs("post_reset");
        m_cv = 1'b0; z_cv = 1'b0; last_g = 1'b1;
        m68k_read(23'h000100, 1);
        z80_read(16'h0003, 0);

        download_read(23'h000100, 2);
        m68k_read(23'h000100, 2);
        download_inflight(23'h000600, 3);
        m68k_read(23'h000600, 1);

        for (int it = 0; it < 50; it++) begin
            int op, lat;
            op  = $urandom_range(0, 9);
            lat = $urandom_range(0, 4);
            if (op <= 3)      m68k_read(m_pool[$urandom_range(0, 3)], lat);
            else if (op <= 6) z80_read(z_pool[$urandom_range(0, 5)], lat);
            else if (op <= 8) both_read(m_pool[$urandom_range(0, 3)], z_pool[$urandom_range(0, 5)], lat);
            else              download_read(m_pool[$urandom_range(0, 3)], lat);
        end

        repeat (3) @(negedge clk_sys);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
